dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Sequencer and arbiter in front of the 512-word data memory. It shares the single memory port between the core load/store stage and the debug/loader port, and turns byte, halfword and word requests into word-addressed memory accesses. Sub-word stores use a same-cycle read-modify-write; misaligned accesses are split into two word accesses. Sits between the execute/memory stage and the data memory.

## Interface
- DEPTH_WORDS, 512, number of 32-bit words in data memory
- STARVE_MAX, 8, consecutive stalled debug cycles before debug is force-granted
- clk  in  1  clock; memory writes happen on its falling edge
- rst_n  in  1  asynchronous, active-low reset
- core_req  in  1  core access request; held stable until core_ready
- core_we  in  1  1 = store, 0 = load
- core_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal (flags core_err)
- core_unsigned  in  1  zero-extend a load result (lbu/lhu)
- core_addr  in  32  byte address
- core_wdata  in  32  store data, right-justified
- core_rdata  out  32  load data, extended; valid while core_ready
- core_ready  out  1  access complete this cycle
- core_err  out  1  with core_ready: range, size or alignment error; no write performed
- dbg_req / dbg_we  in  1 / 1  debug word access request / write
- dbg_addr  in  30  word address
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  debug read data
- dbg_ready  out  1  debug access complete this cycle
- mem_addr  out  30  to memory address
- mem_wdata  out  32  to memory write data
- mem_we / mem_re  out  1 / 1  memory write enable / read enable
- mem_rdata  in  32  asynchronous memory read data

## Operation
- Grant rules:
  - The core has priority.
  - Debug is granted when core_req is low, or when the starve counter equals STARVE_MAX.
  - A forced debug grant lasts one cycle; core_ready is 0 in that cycle.
  - A debug grant is never inserted while the FSM is in SECOND.
- Starve counter:
  - Increments each cycle dbg_req is high and not granted.
  - Clears on a debug grant or when dbg_req is low.
  - Saturates at STARVE_MAX.
- FSM states: IDLE and SECOND.
  - IDLE → SECOND: only on a granted misaligned core access that does not error.
  - SECOND → IDLE: unconditionally after one cycle.
- Aligned access (word at addr%4==0, half at addr%4∈{0,2}, any byte):
  - Completes in one cycle.
  - Loads: extract and extend the lane from mem_rdata.
  - Stores: merge the lanes into mem_rdata of the same word, then drive mem_we.
- Misaligned access:
  - Cycle 0 (IDLE) accesses word A and captures the low part in a holding register.
  - Cycle 1 (SECOND) accesses word A+1.
  - core_ready asserts in the SECOND cycle only.
  - Misaligned stores write both words, low word first.
- Errors (core_ready=1, core_err=1 in one cycle; no mem_we; FSM stays in IDLE):
  - Word address ≥ DEPTH_WORDS, checked for both words of a split access before anything is written.
  - core_size=3.
- Debug accesses: always single-cycle, word only, with no alignment logic.
- mem_re = 1 whenever a grant is active.

## Timing
- Reset values: FSM=IDLE, starve counter=0, holding register=0.
- While rst_n=0, all outputs are 0 (including mem_we).
- Latency:
  - Aligned or error access: 0 extra cycles (ready in the request cycle).
  - Misaligned access: 1 extra cycle.
  - Forced debug grant: delays the core by 1 cycle.
- Write commits on the falling edge of the grant cycle; read data is combinational within the cycle.
- Reset asserted in SECOND aborts the access. The first word may already be written; this is accepted.
- core_req dropping while in SECOND is a protocol violation; the access completes anyway.

## Configuration
- DMEM_CTRL_MISALIGN_EN defined: misaligned accesses are split as described above.
- DMEM_CTRL_MISALIGN_EN undefined:
  - Any misaligned access returns core_ready=1, core_err=1 in one cycle with no write.
  - The SECOND state and holding register are not built.

## Structure
- Shared package dmem_ctrl_pkg holds:
  - size_e (SZ_B, SZ_H, SZ_W)
  - state_e (IDLE, SECOND)
  - default constants DEPTH_WORDS and STARVE_MAX
- One sub-module, dmem_lane_align (purely combinational), does:
  - store lane merge from (addr[1:0], size, wdata, old word, part)
  - load lane extraction and sign/zero extension
- dmem_ctrl contains the arbiter, starve counter, FSM and holding register.

## Test plan
- Aligned sw 0xDEADBEEF to 0x40, then lw from 0x40:
  - Each access has core_ready in the same cycle.
  - core_rdata=0xDEADBEEF.
- sb 0x7F to 0x41 over word 0x11223344, then lb from 0x41 and lhu from 0x42:
  - Word becomes 0x11227F44.
  - lb returns 0x0000007F; lhu returns 0x00001122.
- Misaligned lw at 0x43 (macro on), with words 0x44332211 and 0x88776655:
  - core_ready in the 2nd cycle.
  - core_rdata=0x77665544.
- Same misaligned lw with the macro off:
  - core_ready=1, core_err=1 in the 1st cycle.
  - mem_we never asserted.
- Core requests held continuously and dbg_req held (STARVE_MAX=8):
  - dbg_ready asserts on the 9th cycle.
  - core_ready=0 that cycle.
  - Starve counter returns to 0.
- sw to 0x800, and misaligned sh at 0x7FF:
  - core_err=1 for both.
  - No memory word changes.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and default constants for the data-memory sequencer.
package dmem_ctrl_pkg;

  localparam int unsigned DEPTH_WORDS = 512;
  localparam int unsigned STARVE_MAX  = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  // Byte-enable pattern for an access of the given size, starting at lane 0.
  function automatic logic [3:0] size_mask(logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into a memory word and extracts/extends load data.
// part selects the word of a split access (0 = low word, 1 = following word).
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        part,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  input  logic [31:0] hold_word,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  sh;
  logic [63:0] wd_sh;
  logic [7:0]  mask_sh;
  logic [31:0] lane_d;
  logic [3:0]  lane_m;
  logic [63:0] rd_pair;
  logic [31:0] rd_lo;

  assign sh = {off, 3'b000};

  always_comb begin
    wd_sh   = {32'h0, wdata} << sh;
    mask_sh = {4'h0, size_mask(size)} << off;
    lane_d  = part ? wd_sh[63:32] : wd_sh[31:0];
    lane_m  = part ? mask_sh[7:4] : mask_sh[3:0];
    merged  = old_word;
    for (int j = 0; j < 4; j++) begin
      if (lane_m[j]) merged[8*j +: 8] = lane_d[8*j +: 8];
    end

    // A split load sees the held low word below the current word.
    rd_pair = part ? {old_word, hold_word} : {32'h0, old_word};
    rd_lo   = 32'(rd_pair >> sh);
    case (size_e'(size))
      SZ_B:    load_data = is_unsigned ? {24'h0, rd_lo[7:0]} : {{24{rd_lo[7]}}, rd_lo[7:0]};
      SZ_H:    load_data = is_unsigned ? {16'h0, rd_lo[15:0]} : {{16{rd_lo[15]}}, rd_lo[15:0]};
      default: load_data = rd_lo;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Core/debug arbiter and access sequencer for the word-addressed data memory.
// Define DMEM_CTRL_MISALIGN_EN to split misaligned accesses; otherwise they return an error.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = dmem_ctrl_pkg::DEPTH_WORDS,
  parameter int unsigned STARVE_MAX  = dmem_ctrl_pkg::STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ready,
  output logic        core_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [29:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ready,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);
  import dmem_ctrl_pkg::*;

  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

`ifdef DMEM_CTRL_MISALIGN_EN
  localparam logic MisalignEn = 1'b1;
`else
  localparam logic MisalignEn = 1'b0;
`endif

  logic          in_second;
  logic [31:0]   hold_word;
  logic [29:0]   word_a;
  logic [30:0]   word_b;
  logic [1:0]    off;
  logic          misaligned;
  logic          size_err;
  logic          range_err;
  logic          acc_err;
  logic [SW-1:0] starve_q, starve_d;
  logic          starve_full;
  logic          dbg_grant;
  logic          core_grant;
  logic [31:0]   merged;
  logic [31:0]   load_data;

  assign word_a = core_addr[31:2];
  assign off    = core_addr[1:0];
  assign word_b = {1'b0, word_a} + 31'd1;

  assign misaligned = ((core_size == 2'd1) && off[0]) || ((core_size == 2'd2) && (off != 2'd0));
  assign size_err   = (core_size == 2'd3);
  // Both words of a split access are range-checked before the first one is written.
  assign range_err  = ({2'b00, word_a} >= DEPTH_WORDS) ||
                      (misaligned && ({1'b0, word_b} >= DEPTH_WORDS));
  assign acc_err    = !in_second && (size_err || range_err || (misaligned && !MisalignEn));

  assign starve_full = (starve_q == SW'(STARVE_MAX));
  assign dbg_grant   = !in_second && dbg_req && (!core_req || starve_full);
  assign core_grant  = in_second || (core_req && !dbg_grant);

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || dbg_grant) begin
      starve_d = '0;
    end else if (!starve_full) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

`ifdef DMEM_CTRL_MISALIGN_EN
  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        split_go;

  assign split_go = core_grant && !in_second && misaligned && !acc_err;

  always_comb begin
    state_d = IDLE;
    hold_d  = hold_q;
    if (state_q == IDLE && split_go) begin
      state_d = SECOND;
      hold_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign in_second = (state_q == SECOND);
  assign hold_word = hold_q;
`else
  assign in_second = 1'b0;
  assign hold_word = '0;
`endif

  dmem_lane_align u_align (
    .off         (off),
    .size        (core_size),
    .is_unsigned (core_unsigned),
    .part        (in_second),
    .wdata       (core_wdata),
    .old_word    (mem_rdata),
    .hold_word   (hold_word),
    .merged      (merged),
    .load_data   (load_data)
  );

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    core_ready = 1'b0;
    core_err   = 1'b0;
    core_rdata = '0;
    dbg_ready  = 1'b0;
    dbg_rdata  = '0;
    if (rst_n) begin
      if (dbg_grant) begin
        mem_re    = 1'b1;
        mem_addr  = dbg_addr;
        mem_we    = dbg_we;
        mem_wdata = dbg_wdata;
        dbg_ready = 1'b1;
        dbg_rdata = mem_rdata;
      end else if (core_grant) begin
        mem_re   = 1'b1;
        mem_addr = in_second ? word_b[29:0] : word_a;
        if (acc_err) begin
          core_ready = 1'b1;
          core_err   = 1'b1;
        end else begin
          mem_we    = core_we;
          mem_wdata = merged;
          if (in_second || !misaligned) begin
            core_ready = 1'b1;
            core_rdata = core_we ? 32'h0 : load_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a behavioural 512-word memory.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we, core_unsigned;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_ready, core_err;
  logic        dbg_req, dbg_we, dbg_ready;
  logic [29:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem [512];
  int n_cmp  = 0;
  int n_fail = 0;

  dmem_ctrl #(
    .DEPTH_WORDS (512),
    .STARVE_MAX  (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_rdata    (core_rdata),
    .core_ready    (core_ready),
    .core_err      (core_err),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_rdata     (dbg_rdata),
    .dbg_ready     (dbg_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 30'd512) ? mem[mem_addr[8:0]] : 32'h0;
  always @(negedge clk) begin
    if (mem_we && mem_addr < 30'd512) mem[mem_addr[8:0]] = mem_wdata;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    core_req = 0; core_we = 0; core_size = 2'd0; core_unsigned = 0;
    core_addr = 32'h0; core_wdata = 32'h0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 30'h0; dbg_wdata = 32'h0;
  endtask

  task automatic core_set(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    core_req = 1; core_we = we; core_size = size; core_unsigned = uns;
    core_addr = addr; core_wdata = wdata;
  endtask

  task automatic dbg_write(input logic [29:0] a, input logic [31:0] d);
    dbg_req = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = d;
    next_cycle();
    dbg_req = 0; dbg_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    next_cycle();
    core_set(1, 2'd2, 0, 32'h40, 32'hFFFF_FFFF);
    dbg_req = 1; dbg_we = 1; dbg_addr = 30'h10; dbg_wdata = 32'h1234_5678;
    #2;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re: got %b want 0", mem_re); end
    n_cmp++; if (core_ready !== 1'b0) begin n_fail++; $display("FAIL rst_core_ready: got %b want 0", core_ready); end
    n_cmp++; if (dbg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dbg_ready: got %b want 0", dbg_ready); end
    n_cmp++; if (mem_addr !== 30'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    next_cycle();
    idle_all();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_word();
    core_set(1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF);
    #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready: got %b want 1", core_ready); end
    n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", core_err); end
    n_cmp++; if (mem_addr !== 30'h10) begin n_fail++; $display("FAIL sw_addr: got %h want 10", mem_addr); end
    next_cycle(); idle_all();
    n_cmp++; if (mem[16] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_mem: got %h want deadbeef", mem[16]); end
    core_set(0, 2'd2, 0, 32'h40, 32'h0);
    #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready: got %b want 1", core_ready); end
    n_cmp++; if (core_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", core_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", mem_we); end
    next_cycle(); idle_all();
  endtask

  task automatic test_subword();
    dbg_write(30'h10, 32'h1122_3344);
    core_set(1, 2'd0, 0, 32'h41, 32'h0000_007F);
    #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready: got %b want 1", core_ready); end
    n_cmp++; if (mem_wdata !== 32'h1122_7F44) begin n_fail++; $display("FAIL sb_wdata: got %h want 11227f44", mem_wdata); end
    next_cycle(); idle_all();
    n_cmp++; if (mem[16] !== 32'h1122_7F44) begin n_fail++; $display("FAIL sb_mem: got %h want 11227f44", mem[16]); end
    core_set(0, 2'd0, 0, 32'h41, 32'h0); #2;
    n_cmp++; if (core_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_41: got %h want 0000007f", core_rdata); end
    next_cycle();
    core_set(0, 2'd1, 1, 32'h42, 32'h0); #2;
    n_cmp++; if (core_rdata !== 32'h0000_1122) begin n_fail++; $display("FAIL lhu_42: got %h want 00001122", core_rdata); end
    next_cycle();
    core_set(1, 2'd0, 0, 32'h43, 32'hFFFF_FF80); #2;
    next_cycle(); idle_all();
    n_cmp++; if (mem[16] !== 32'h8022_7F44) begin n_fail++; $display("FAIL sb_43_mem: got %h want 80227f44", mem[16]); end
    core_set(0, 2'd0, 0, 32'h43, 32'h0); #2;
    n_cmp++; if (core_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_43: got %h want ffffff80", core_rdata); end
    next_cycle();
    core_set(0, 2'd0, 1, 32'h43, 32'h0); #2;
    n_cmp++; if (core_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_43: got %h want 00000080", core_rdata); end
    next_cycle();
    core_set(0, 2'd1, 0, 32'h42, 32'h0); #2;
    n_cmp++; if (core_rdata !== 32'hFFFF_8022) begin n_fail++; $display("FAIL lh_42: got %h want ffff8022", core_rdata); end
    next_cycle(); idle_all();
  endtask

  task automatic test_misaligned();
    dbg_write(30'h10, 32'h4433_2211);
    dbg_write(30'h11, 32'h8877_6655);
    core_set(0, 2'd2, 0, 32'h43, 32'h0);
    #2;
`ifdef DMEM_CTRL_MISALIGN_EN
    n_cmp++; if (core_ready !== 1'b0) begin n_fail++; $display("FAIL mis_lw_c0_ready: got %b want 0", core_ready); end
    n_cmp++; if (mem_addr !== 30'h10) begin n_fail++; $display("FAIL mis_lw_c0_addr: got %h want 10", mem_addr); end
    next_cycle(); #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL mis_lw_c1_ready: got %b want 1", core_ready); end
    n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL mis_lw_c1_err: got %b want 0", core_err); end
    n_cmp++; if (mem_addr !== 30'h11) begin n_fail++; $display("FAIL mis_lw_c1_addr: got %h want 11", mem_addr); end
    n_cmp++; if (core_rdata !== 32'h7766_5544) begin n_fail++; $display("FAIL mis_lw_data: got %h want 77665544", core_rdata); end
    next_cycle(); idle_all();
    core_set(1, 2'd2, 0, 32'h42, 32'hAABB_CCDD);
    #2;
    n_cmp++; if (core_ready !== 1'b0) begin n_fail++; $display("FAIL mis_sw_c0_ready: got %b want 0", core_ready); end
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mis_sw_c0_we: got %b want 1", mem_we); end
    next_cycle(); #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL mis_sw_c1_ready: got %b want 1", core_ready); end
    n_cmp++; if (mem_addr !== 30'h11) begin n_fail++; $display("FAIL mis_sw_c1_addr: got %h want 11", mem_addr); end
    next_cycle(); idle_all();
    n_cmp++; if (mem[16] !== 32'hCCDD_2211) begin n_fail++; $display("FAIL mis_sw_lo: got %h want ccdd2211", mem[16]); end
    n_cmp++; if (mem[17] !== 32'h8877_AABB) begin n_fail++; $display("FAIL mis_sw_hi: got %h want 8877aabb", mem[17]); end
    core_set(0, 2'd1, 0, 32'h43, 32'h0);
    next_cycle(); #2;
    n_cmp++; if (core_rdata !== 32'hFFFF_BBCC) begin n_fail++; $display("FAIL mis_lh_data: got %h want ffffbbcc", core_rdata); end
    next_cycle(); idle_all();
`else
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL mis_lw_ready: got %b want 1", core_ready); end
    n_cmp++; if (core_err !== 1'b1) begin n_fail++; $display("FAIL mis_lw_err: got %b want 1", core_err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mis_lw_we: got %b want 0", mem_we); end
    next_cycle(); idle_all();
    core_set(1, 2'd2, 0, 32'h42, 32'hAABB_CCDD);
    #2;
    n_cmp++; if (core_err !== 1'b1) begin n_fail++; $display("FAIL mis_sw_err: got %b want 1", core_err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mis_sw_we: got %b want 0", mem_we); end
    next_cycle(); idle_all();
    n_cmp++; if (mem[16] !== 32'h4433_2211) begin n_fail++; $display("FAIL mis_sw_lo: got %h want 44332211", mem[16]); end
    n_cmp++; if (mem[17] !== 32'h8877_6655) begin n_fail++; $display("FAIL mis_sw_hi: got %h want 88776655", mem[17]); end
`endif
    core_set(0, 2'd2, 0, 32'h44, 32'h0);
    #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL post_mis_ready: got %b want 1", core_ready); end
    next_cycle(); idle_all();
  endtask

  task automatic test_debug();
    dbg_write(30'h10, 32'h0BAD_F00D);
    dbg_write(30'h11, 32'h1234_5678);
    n_cmp++; if (mem[17] !== 32'h1234_5678) begin n_fail++; $display("FAIL dbg_wr_mem: got %h want 12345678", mem[17]); end
    dbg_req = 1; dbg_we = 0; dbg_addr = 30'h11;
    #2;
    n_cmp++; if (dbg_ready !== 1'b1) begin n_fail++; $display("FAIL dbg_rd_ready: got %b want 1", dbg_ready); end
    n_cmp++; if (dbg_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dbg_rd_data: got %h want 12345678", dbg_rdata); end
    n_cmp++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL dbg_rd_re: got %b want 1", mem_re); end
    next_cycle(); idle_all();
  endtask

  task automatic test_starve();
    logic exp_dbg;
    core_set(0, 2'd2, 0, 32'h40, 32'h0);
    dbg_req = 1; dbg_we = 0; dbg_addr = 30'h11;
    for (int i = 0; i < 18; i++) begin
      #2;
      exp_dbg = (i == 8) || (i == 17);
      n_cmp++;
      if (dbg_ready !== exp_dbg) begin
        n_fail++; $display("FAIL starve_dbg_ready[%0d]: got %b want %b", i, dbg_ready, exp_dbg);
      end
      n_cmp++;
      if (core_ready !== !exp_dbg) begin
        n_fail++; $display("FAIL starve_core_ready[%0d]: got %b want %b", i, core_ready, !exp_dbg);
      end
      n_cmp++;
      if (exp_dbg) begin
        if (dbg_rdata !== 32'h1234_5678) begin
          n_fail++; $display("FAIL starve_dbg_data[%0d]: got %h want 12345678", i, dbg_rdata);
        end
      end else if (core_rdata !== 32'h0BAD_F00D) begin
        n_fail++; $display("FAIL starve_core_data[%0d]: got %h want 0badf00d", i, core_rdata);
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_range();
    dbg_write(30'h1FF, 32'hCAFE_F00D);
    core_set(1, 2'd2, 0, 32'h800, 32'h1111_1111);
    #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL rng_sw_ready: got %b want 1", core_ready); end
    n_cmp++; if (core_err !== 1'b1) begin n_fail++; $display("FAIL rng_sw_err: got %b want 1", core_err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rng_sw_we: got %b want 0", mem_we); end
    next_cycle(); idle_all();
    core_set(1, 2'd1, 0, 32'h7FF, 32'h0000_2222);
    #2;
    n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL rng_sh_ready: got %b want 1", core_ready); end
    n_cmp++; if (core_err !== 1'b1) begin n_fail++; $display("FAIL rng_sh_err: got %b want 1", core_err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rng_sh_we: got %b want 0", mem_we); end
    next_cycle(); idle_all();
    n_cmp++; if (mem[511] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rng_mem_1ff: got %h want cafef00d", mem[511]); end
    core_set(1, 2'd3, 0, 32'h40, 32'h3333_3333);
    #2;
    n_cmp++; if (core_err !== 1'b1) begin n_fail++; $display("FAIL size3_err: got %b want 1", core_err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL size3_we: got %b want 0", mem_we); end
    next_cycle(); idle_all();
    n_cmp++; if (mem[16] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL size3_mem: got %h want 0badf00d", mem[16]); end
  endtask

  initial begin
    idle_all();
    rst_n = 0;
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_debug();
    test_starve();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
